fifo_stream_reader: RTL

Read-side controller for the synchronous FIFO. It drives the FIFO read port (rd_en, rd_data, empty) and presents the data as a valid/ready output stream. The FIFO has a 1-cycle read latency, so the block holds a 2-entry skid buffer and tracks one in-flight read. It sits between the FIFO and any downstream consumer that may stall.

---
 rtl/fifo_stream_reader.sv | 72 +++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO into a valid/ready stream via a 2-entry skid buffer; STREAM_LAST_EN adds m_last burst framing
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  busy
);
  logic [1:0]            occ_q, occ_d, level, cap_idx;
  logic                  inflight_q, inflight_d, pop;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  assign m_valid   = occ_q != 2'd0;
  assign m_data    = m_valid ? buf0_q : '0;
  assign words_out = words_q;
  assign busy      = m_valid || inflight_q;
  // issue, capture and skid-buffer shifting; level counts words held or owed after this edge
  always_comb begin
    pop        = m_valid && m_ready;
    level      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    cap_idx    = occ_q - {1'b0, pop};
    fifo_rd_en = rst_n && en && !fifo_empty && level < 2'd2;
    occ_d      = level;
    inflight_d = fifo_rd_en;
    words_d    = words_q + CNT_WIDTH'(pop);
    buf0_d     = (pop && occ_q == 2'd2) ? buf1_q : buf0_q;
    buf1_d     = buf1_q;
    if (inflight_q && cap_idx == 2'd0) buf0_d = fifo_rd_data;
    if (inflight_q && cap_idx == 2'd1) buf1_d = fifo_rd_data;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      words_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      words_q    <= words_d;
    end
  end
`ifdef STREAM_LAST_EN
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  assign m_last = m_valid && beat_cnt_q == BW'(BURST_LEN - 1);
  // beat position within the current burst, wrapping on the last beat
  always_comb beat_cnt_d = pop ? (m_last ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
  // beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else beat_cnt_q <= beat_cnt_d;
  end
`else
  assign m_last = 1'b0;
`endif
endmodule
